// File: rtl/fa_bist_checker.sv
// Exhaustive on-chip tester for a 1-bit full adder: walks vectors 000..111, checks {carry,sum}.
// Latency: 8*(SETTLE+1) cycles from the start edge to the cycle holding the one-cycle done pulse.
// No backpressure: start is sampled only in IDLE; pulses arriving during a run are ignored.
module fa_bist_checker #(
    // Cycles each vector is held before its response is sampled; legal range 1..15.
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_cin,
    input  logic       dut_sum,
    input  logic       dut_carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec,
    output logic [2:0] first_fail
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    logic [2:0] first_q, first_d;
    logic       pass_q, pass_d;

    logic [1:0] exp_resp;
    logic       mismatch;

    // Reference response for the vector currently applied: a + b + cin as a 2-bit value.
    always_comb begin
        exp_resp = {1'b0, vec_q[2]} + {1'b0, vec_q[1]} + {1'b0, vec_q[0]};
        mismatch = ({dut_carry, dut_sum} != exp_resp);
    end

    // Next-state logic for the run sequencer and result accumulators.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        fail_d     = fail_q;
        first_d    = first_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d      = 3'd0;
                    wait_cnt_d = 4'd0;
                    err_d      = 4'd0;
                    fail_d     = 8'h00;
                    first_d    = 3'd0;
                    pass_d     = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The vector is held for exactly SETTLE cycles before CHECK.
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d  = err_q + 4'd1;
                    fail_d = fail_q | (8'd1 << vec_q);
                    // Vectors are visited in ascending order, so the first hit is the lowest.
                    if (err_q == 4'd0) begin
                        first_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d      = vec_q + 3'd1;
                    wait_cnt_d = 4'd0;
                    state_d    = ST_WAIT;
                end
            end
            ST_DONE: begin
                // err_q already includes the final vector's update from the last CHECK.
                pass_d  = (err_q == 4'd0);
                vec_d   = 3'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= 3'd0;
            wait_cnt_q <= 4'd0;
            err_q      <= 4'd0;
            fail_q     <= 8'h00;
            first_q    <= 3'd0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            first_q    <= first_d;
            pass_q     <= pass_d;
        end
    end

    // The vector register drives the adder directly, so its inputs are glitch-free.
    assign dut_a      = vec_q[2];
    assign dut_b      = vec_q[1];
    assign dut_cin    = vec_q[0];
    assign busy       = (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fail_q;
    assign first_fail = first_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: three instances (SETTLE 2, 1, 3) each beside a behavioural adder.
// Instance 0 sees a fault-injectable adder; instances 1 and 2 see an adder lagging by 2 cycles.
// Expected results come from arithmetic on vector indices and the run timeline.
module tb_fa_bist_checker;

    logic clk;
    logic rst;
    logic [2:0] start_v;
    logic [2:0] a_w, b_w, c_w, sum_w, car_w, busy_w, done_w, pass_w;
    logic [2:0][3:0] err_w;
    logic [2:0][7:0] fv_w;
    logic [2:0][2:0] ff_w;

    int n_chk  = 0;
    int n_fail = 0;

    // Fault controls for the adder beside instance 0.
    logic [7:0] fmask;
    logic       stuck;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fa_bist_checker #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_cin(c_w[0]),
        .dut_sum(sum_w[0]), .dut_carry(car_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_vec(fv_w[0]), .first_fail(ff_w[0]));

    fa_bist_checker #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_cin(c_w[1]),
        .dut_sum(sum_w[1]), .dut_carry(car_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_vec(fv_w[1]), .first_fail(ff_w[1]));

    fa_bist_checker #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .dut_a(a_w[2]), .dut_b(b_w[2]), .dut_cin(c_w[2]),
        .dut_sum(sum_w[2]), .dut_carry(car_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_vec(fv_w[2]), .first_fail(ff_w[2]));

    // Adder models: instance 0 with optional sum inversion per vector and carry stuck at 0.
    logic [1:0] tot0, tot1, tot2;
    logic [2:0] l1_1, l2_1, l1_2, l2_2;
    always_comb begin
        tot0     = 2'(a_w[0]) + 2'(b_w[0]) + 2'(c_w[0]);
        sum_w[0] = tot0[0] ^ fmask[{a_w[0], b_w[0], c_w[0]}];
        car_w[0] = stuck ? 1'b0 : tot0[1];
        tot1     = 2'(l2_1[2]) + 2'(l2_1[1]) + 2'(l2_1[0]);
        sum_w[1] = tot1[0];
        car_w[1] = tot1[1];
        tot2     = 2'(l2_2[2]) + 2'(l2_2[1]) + 2'(l2_2[0]);
        sum_w[2] = tot2[0];
        car_w[2] = tot2[1];
    end

    // Two-stage input delay for the lagging adders.
    always @(posedge clk) begin
        l1_1 <= {a_w[1], b_w[1], c_w[1]};
        l2_1 <= l1_1;
        l1_2 <= {a_w[2], b_w[2], c_w[2]};
        l2_2 <= l1_2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int sel);
        case (sel)
            0: return 2;
            1: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int bits3(input int v);
        return ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
    endfunction

    // Which vectors fail when instance 0's adder has the given faults.
    function automatic logic [7:0] fault_fv(input logic [7:0] mask, input logic stk);
        logic [7:0] fv;
        fv = 8'h00;
        for (int v = 0; v < 8; v++) begin
            int tot, osum, ocar;
            tot  = bits3(v);
            osum = (tot % 2) ^ int'(mask[v]);
            ocar = stk ? 0 : tot / 2;
            fv[v] = ((2 * ocar + osum) != tot);
        end
        return fv;
    endfunction

    // With a 2-cycle lag, the value seen in vector v's check cycle was driven 2 cycles earlier.
    function automatic logic [7:0] lag_fv(input int s);
        logic [7:0] fv;
        fv = 8'h00;
        for (int v = 0; v < 8; v++) begin
            int tchk, seen;
            tchk = v * (s + 1) + s;
            seen = (tchk - 2 >= 0) ? (tchk - 2) / (s + 1) : 0;
            fv[v] = (bits3(seen) != bits3(v));
        end
        return fv;
    endfunction

    // One run on instance sel: start held for `hold` edges, checked cycle by cycle to IDLE.
    task automatic run(input int sel, input int hold, input logic [7:0] exp_fv);
        int s, len, ndone, exp_err, exp_ff;
        s = settle_of(sel);
        len = 8 * (s + 1);
        exp_err = 0;
        exp_ff = 0;
        for (int v = 7; v >= 0; v--) begin
            if (exp_fv[v]) begin
                exp_err++;
                exp_ff = v;
            end
        end
        ndone = 0;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= len + 1; t++) begin
            @(negedge clk);
            if (t + 1 >= hold) start_v[sel] = 1'b0;
            ndone += int'(done_w[sel]);
            if (t <= len) begin
                chk($sformatf("vec s%0d t%0d", s, t), 32'({a_w[sel], b_w[sel], c_w[sel]}),
                    32'((t < len) ? t / (s + 1) : 7));
                chk($sformatf("busy s%0d t%0d", s, t), 32'(busy_w[sel]), 32'(t < len));
                chk($sformatf("done s%0d t%0d", s, t), 32'(done_w[sel]), 32'(t == len));
            end
            if (t == 0) begin
                chk($sformatf("clr_pass s%0d", s), 32'(pass_w[sel]), 32'd0);
                chk($sformatf("clr_err s%0d", s), 32'(err_w[sel]), 32'd0);
                chk($sformatf("clr_fv s%0d", s), 32'(fv_w[sel]), 32'd0);
            end
        end
        chk($sformatf("ndone s%0d", s), 32'(ndone), 32'd1);
        chk($sformatf("vec_idle s%0d", s), 32'({a_w[sel], b_w[sel], c_w[sel]}), 32'd0);
        chk($sformatf("pass s%0d", s), 32'(pass_w[sel]), 32'(exp_err == 0));
        chk($sformatf("err s%0d", s), 32'(err_w[sel]), 32'(exp_err));
        chk($sformatf("fail_vec s%0d", s), 32'(fv_w[sel]), 32'(exp_fv));
        if (exp_err != 0) chk($sformatf("first_fail s%0d", s), 32'(ff_w[sel]), 32'(exp_ff));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec"},  32'({a_w[0], b_w[0], c_w[0]}), 32'd0);
        chk({tag, "_busy"}, 32'(busy_w[0]), 32'd0);
        chk({tag, "_done"}, 32'(done_w[0]), 32'd0);
        chk({tag, "_pass"}, 32'(pass_w[0]), 32'd0);
        chk({tag, "_err"},  32'(err_w[0]), 32'd0);
        chk({tag, "_fv"},   32'(fv_w[0]), 32'd0);
        chk({tag, "_ff"},   32'(ff_w[0]), 32'd0);
    endtask

    initial begin
        int ndone;
        logic [7:0] m;
        logic       sk;
        rst = 1'b1;
        start_v = 3'b000;
        fmask = 8'h00;
        stuck = 1'b0;
        idle(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        idle(2);

        // Golden adder, then carry stuck at 0, then sum inverted on every vector.
        run(0, 1, fault_fv(8'h00, 1'b0));
        stuck = 1'b1;
        run(0, 1, fault_fv(8'h00, 1'b1));
        stuck = 1'b0;
        fmask = 8'hFF;
        run(0, 1, fault_fv(8'hFF, 1'b0));

        // Random fault patterns, random start-pulse lengths and idle gaps.
        for (int i = 0; i < 6; i++) begin
            m = 8'($urandom_range(0, 255));
            sk = 1'($urandom_range(0, 1));
            fmask = m;
            stuck = sk;
            idle($urandom_range(0, 3));
            run(0, $urandom_range(1, 5), fault_fv(m, sk));
        end

        // start held for 40 edges: second run begins after the first DONE and clears results.
        fmask = 8'h00;
        stuck = 1'b1;
        idle(2);
        run(0, 40, fault_fv(8'h00, 1'b1));
        ndone = 0;
        for (int t = 26; t <= 51; t++) begin
            @(negedge clk);
            if (t + 1 >= 40) start_v[0] = 1'b0;
            ndone += int'(done_w[0]);
            if (t == 26) begin
                chk("held_busy2", 32'(busy_w[0]), 32'd1);
                chk("held_clr_err", 32'(err_w[0]), 32'd0);
                chk("held_clr_fv", 32'(fv_w[0]), 32'd0);
            end
            if (t == 50) chk("held_done2", 32'(done_w[0]), 32'd1);
        end
        chk("held_ndone2", 32'(ndone), 32'd1);
        chk("held_err2", 32'(err_w[0]), 32'd4);
        chk("held_fv2", 32'(fv_w[0]), 32'hE8);
        chk("held_busy_end", 32'(busy_w[0]), 32'd0);

        // Reset in cycle 10 of a faulty run aborts it; a golden rerun then passes.
        stuck = 1'b0;
        fmask = 8'h07;
        idle(2);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= 9; t++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (t == 9) begin
                chk("pre_rst_err", 32'(err_w[0]), 32'd3);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid_rst");
        ndone = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            ndone += int'(done_w[0]);
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        fmask = 8'h00;
        run(0, 1, fault_fv(8'h00, 1'b0));

        // Lagging adder: too short a settle time fails, a longer one passes.
        run(1, 1, lag_fv(1));
        chk("lag_s1_nonzero", 32'(err_w[1] != 4'd0), 32'd1);
        run(2, 1, lag_fv(3));
        chk("lag_s3_pass", 32'(pass_w[2]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
